// File: rtl/alu_pkg.sv
// Shared opcode encodings, decode helpers and issue FSM states
// for the vector ALU issue path and the ALU controller.
package alu_pkg;

  typedef enum logic [3:0] {
    INST_ANDVE = 4'd0,
    INST_ANDVV = 4'd1,
    INST_ORVE  = 4'd2,
    INST_ORVV  = 4'd3,
    INST_XORE  = 4'd4,
    INST_XORVV = 4'd5,
    INST_ADDVV = 4'd6,
    INST_SUBVV = 4'd7,
    INST_SLLVV = 4'd8,
    INST_SRLVV = 4'd9,
    INST_SVV   = 4'd10,
    INST_SVE   = 4'd11,
    INST_RVV   = 4'd12,
    INST_RVE   = 4'd13
  } inst_op_e;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_RDY,
    WB
  } issue_state_e;

  function automatic logic is_vector_scalar(
    input logic [3:0] op
  );
    return op inside {INST_ANDVE, INST_ORVE,
                      INST_XORE, INST_SVE,
                      INST_RVE};
  endfunction

  function automatic logic is_legal_alu_op(
    input logic [3:0] op
  );
    return op <= INST_RVE;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_fifo.sv
// Circular instruction queue between decode and the issue FSM.
// Head entry is presented combinationally on rdata.
module vec_instr_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Queues decoded vector ALU instructions and issues them one at a
// time over the start/ready handshake, with writeback and watchdog.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [3:0]            instr_op,
  input  logic [REG_ADDR_W-1:0] instr_vd,
  input  logic [REG_ADDR_W-1:0] instr_vs1,
  input  logic [REG_ADDR_W-1:0] instr_vs2,
  output logic                  alu_start,
  output logic [3:0]            alu_op,
  input  logic                  alu_rdy,
  output logic [REG_ADDR_W-1:0] rf_rd_addr_a,
  output logic [REG_ADDR_W-1:0] rf_rd_addr_b,
  output logic                  src_b_scalar,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic                  busy,
  output logic                  illegal_op,
  output logic                  timeout_err
);

  localparam int W  = REG_ADDR_W;
  localparam int EW = 4 + 3 * W;
  localparam int CW = $clog2(TIMEOUT);

  issue_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q;
  logic [W-1:0]  vd_q, vs1_q, vs2_q;
  logic          scl_q, ill_q, tmo_q, tmo_d;
  logic          full, empty, pop, hs, push;
  logic [EW-1:0] head;
  logic [3:0]    hd_op;

  assign instr_ready = !full && !reset;
  assign hs          = instr_valid && instr_ready;
  assign push        = hs && is_legal_alu_op(instr_op);
  assign hd_op       = head[EW-1 -: 4];

  vec_instr_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({instr_op, instr_vd,
             instr_vs1, instr_vs2}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        state_d = WAIT_RDY;
        cnt_d   = '0;
      end
      WAIT_RDY: begin
        if (alu_rdy) begin
          state_d = WB;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WB: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      vd_q    <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      scl_q   <= 1'b0;
      ill_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ill_q   <= hs && !is_legal_alu_op(instr_op);
      tmo_q   <= tmo_d;
      // Operand fields hold until the next pop.
      if (pop) begin
        op_q  <= hd_op;
        vd_q  <= head[3*W-1 -: W];
        vs1_q <= head[2*W-1 -: W];
        vs2_q <= head[W-1:0];
        scl_q <= is_vector_scalar(hd_op);
      end
    end
  end

  assign alu_start    = state_q == START;
  assign wb_en        = state_q == WB;
  assign alu_op       = op_q;
  assign rf_rd_addr_a = vs1_q;
  assign rf_rd_addr_b = vs2_q;
  assign src_b_scalar = scl_q;
  assign wb_addr      = vd_q;
  assign illegal_op   = ill_q;
  assign timeout_err  = tmo_q;
  assign busy         = !empty || state_q != IDLE;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: table vectors, directed corner sequences
// and random traffic against a transaction-level issue model.
module tb_alu_issue_ctrl;

  localparam int W     = 3;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         instr_valid = 1'b0;
  logic         instr_ready;
  logic [3:0]   instr_op = '0;
  logic [W-1:0] instr_vd = '0;
  logic [W-1:0] instr_vs1 = '0;
  logic [W-1:0] instr_vs2 = '0;
  logic         alu_start;
  logic [3:0]   alu_op;
  logic         alu_rdy = 1'b0;
  logic [W-1:0] rf_rd_addr_a;
  logic [W-1:0] rf_rd_addr_b;
  logic         src_b_scalar;
  logic         wb_en;
  logic [W-1:0] wb_addr;
  logic         busy;
  logic         illegal_op;
  logic         timeout_err;

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .REG_ADDR_W (W),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_vd     (instr_vd),
    .instr_vs1    (instr_vs1),
    .instr_vs2    (instr_vs2),
    .alu_start    (alu_start),
    .alu_op       (alu_op),
    .alu_rdy      (alu_rdy),
    .rf_rd_addr_a (rf_rd_addr_a),
    .rf_rd_addr_b (rf_rd_addr_b),
    .src_b_scalar (src_b_scalar),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .busy         (busy),
    .illegal_op   (illegal_op),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    int op; int vd; int vs1; int vs2;
    int scl; int legal;
  } vec_t;

  typedef struct {
    int op; int vd; int vs1; int vs2;
    int scl; int p;
  } ent_t;

  ent_t q[$];
  ent_t cur;
  bit   cur_v;
  int   sched[$];
  int   starts[$];
  int   cyc, n_cmp, n_bad;
  int   free_from, s_cyc, wb_cyc, tmo_cyc;
  int   ill_cyc, busy_until, wait_end;
  int   last_op, last_a, last_b, last_s;
  int   dly;
  bit   spur_start, spur_rand, rdy_once;
  bit   offer_v;
  int   o_op, o_vd, o_vs1, o_vs2, o_scl;
  int   acc_cyc, last_wb, last_start;
  int   n_start, n_wb, n_tmo, n_ill, n_nrdy;

  function automatic int ref_scalar(int op);
    return int'(op == 0 || op == 2 || op == 4 ||
                op == 11 || op == 13);
  endfunction

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d",
               nm, cyc, act, exp);
    end
  endfunction

  function automatic void chk_zero(string nm);
    chk(nm, int'({alu_start, alu_op, rf_rd_addr_a,
                  rf_rd_addr_b, src_b_scalar, wb_en,
                  wb_addr, busy, illegal_op,
                  timeout_err, instr_ready}), 0);
  endfunction

  task automatic step();
    int nxt, d;
    bit exp_start, waiting, rdy;
    @(negedge clk);
    cyc++;
    exp_start = 1'b0;
    if (q.size() > 0) begin
      nxt = (free_from > q[0].p + 1) ? free_from
                                      : q[0].p + 1;
      exp_start = (cyc == nxt + 1);
    end
    chk("alu_start", alu_start, exp_start);
    if (alu_start) begin
      n_start++;
      starts.push_back(cyc);
      last_start = cyc;
      chk("start_q_nonempty", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        cur     = q.pop_front();
        cur_v   = 1'b1;
        s_cyc   = cyc;
        last_op = cur.op;
        last_a  = cur.vs1;
        last_b  = cur.vs2;
        last_s  = cur.scl;
        d = (dly > 0) ? dly : int'($urandom_range(1, 10));
        if (d <= 10) sched.push_back(cyc + d);
        if (spur_start) sched.push_back(cyc);
        if (d <= TMO) begin
          wb_cyc     = cyc + d + 1;
          tmo_cyc    = -1;
          free_from  = cyc + d + 1;
          busy_until = cyc + d + 1;
          wait_end   = cyc + d;
        end else begin
          wb_cyc     = -1;
          tmo_cyc    = cyc + TMO + 1;
          free_from  = cyc + TMO + 1;
          busy_until = cyc + TMO;
          wait_end   = cyc + TMO;
        end
      end
    end
    chk("alu_op", alu_op, last_op);
    chk("rf_rd_addr_a", rf_rd_addr_a, last_a);
    chk("rf_rd_addr_b", rf_rd_addr_b, last_b);
    chk("src_b_scalar", src_b_scalar, last_s);
    chk("wb_en", wb_en, int'(cyc == wb_cyc));
    if (wb_en && cyc == wb_cyc)
      chk("wb_addr", wb_addr, cur.vd);
    if (wb_en) begin
      n_wb++;
      last_wb = cyc;
    end
    chk("timeout_err", timeout_err, int'(cyc == tmo_cyc));
    if (timeout_err) n_tmo++;
    chk("illegal_op", illegal_op, int'(cyc == ill_cyc));
    if (illegal_op) n_ill++;
    chk("instr_ready", instr_ready, int'(q.size() < DEPTH));
    chk("busy", busy,
        int'(q.size() > 0 || (cur_v && cyc <= busy_until)));
    if (!instr_ready) n_nrdy++;
    waiting = cur_v && cyc > s_cyc && cyc <= wait_end;
    rdy = 1'b0;
    foreach (sched[i]) if (sched[i] == cyc) rdy = 1'b1;
    if (rdy_once) begin
      rdy = 1'b1;
      rdy_once = 1'b0;
    end
    if (spur_rand && !waiting && $urandom_range(0, 7) == 0)
      rdy = 1'b1;
    alu_rdy     = rdy;
    instr_valid = offer_v;
    instr_op    = o_op[3:0];
    instr_vd    = o_vd[W-1:0];
    instr_vs1   = o_vs1[W-1:0];
    instr_vs2   = o_vs2[W-1:0];
    if (offer_v && q.size() < DEPTH) begin
      if (o_op < 14)
        q.push_back('{o_op, o_vd, o_vs1, o_vs2, o_scl, cyc});
      else
        ill_cyc = cyc + 1;
      offer_v = 1'b0;
      acc_cyc = cyc;
    end
  endtask

  task automatic offer(input int op, input int vd,
                       input int vs1, input int vs2,
                       input int scl);
    o_op = op; o_vd = vd; o_vs1 = vs1;
    o_vs2 = vs2; o_scl = scl;
    offer_v = 1'b1;
    for (int i = 0; i < 100 && offer_v; i++) step();
    chk("offer_accepted", int'(!offer_v), 1);
    offer_v = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    cyc++;
    reset       = 1'b1;
    instr_valid = 1'b0;
    alu_rdy     = 1'b0;
    #1 chk_zero("reset_outputs_now");
    repeat (2) begin
      @(negedge clk);
      cyc++;
      chk_zero("reset_outputs");
    end
    q.delete();
    sched.delete();
    cur_v = 1'b0;
    wb_cyc = -1; tmo_cyc = -1; ill_cyc = -1;
    busy_until = -1; wait_end = -1;
    last_op = 0; last_a = 0; last_b = 0; last_s = 0;
    offer_v = 1'b0;
    reset = 1'b0;
    free_from = cyc;
  endtask

  vec_t tv[11];

  initial begin : main
    int s0, w0, i0, t0, n0, a4, sa;
    tv[0]  = '{11, 2, 1, 3, 1, 1};
    tv[1]  = '{0, 5, 4, 6, 1, 1};
    tv[2]  = '{1, 7, 0, 2, 0, 1};
    tv[3]  = '{2, 1, 2, 3, 1, 1};
    tv[4]  = '{4, 3, 3, 3, 1, 1};
    tv[5]  = '{6, 0, 7, 7, 0, 1};
    tv[6]  = '{10, 6, 5, 4, 0, 1};
    tv[7]  = '{12, 4, 1, 0, 0, 1};
    tv[8]  = '{13, 7, 6, 5, 1, 1};
    tv[9]  = '{14, 1, 1, 1, 0, 0};
    tv[10] = '{15, 2, 2, 2, 0, 0};
    dly = 3;
    apply_reset();

    foreach (tv[i]) begin
      s0 = n_start; w0 = n_wb; i0 = n_ill;
      offer(tv[i].op, tv[i].vd, tv[i].vs1,
            tv[i].vs2, tv[i].scl);
      repeat (10) step();
      chk("tv_starts", n_start - s0, tv[i].legal);
      chk("tv_wb", n_wb - w0, tv[i].legal);
      chk("tv_illegal", n_ill - i0, 1 - tv[i].legal);
      if (tv[i].op == 11) begin
        chk("sve_pop_to_wb", last_wb - (acc_cyc + 1), 5);
        chk("sve_rf_b", rf_rd_addr_b, 3);
        chk("sve_scalar", src_b_scalar, 1);
      end
    end

    // Stalled ALU: queue fills, fifth push waits for a pop.
    dly = 8;
    offer(6, 1, 2, 3, 0);
    step();
    step();
    dly = 3;
    starts.delete();
    n0 = n_nrdy;
    for (int k = 0; k < 5; k++) begin
      offer(2 * k + 1, k, k + 1, 7 - k, 0);
      if (k == 3) a4 = acc_cyc;
    end
    chk("fifth_push_wait", acc_cyc - a4, 6);
    chk("ready_low_cycles", n_nrdy - n0, 5);
    repeat (40) step();
    chk("b2b_count", starts.size(), 5);
    for (int i = 1; i < starts.size(); i++)
      chk("b2b_gap", starts[i] - starts[i-1], 5);

    // Watchdog abort, then the queued op issues.
    dly = 99;
    offer(3, 4, 5, 6, 0);
    step();
    step();
    sa = last_start;
    dly = 3;
    t0 = n_tmo; w0 = n_wb;
    offer(5, 6, 7, 1, 0);
    repeat (25) step();
    chk("tmo_pulses", n_tmo - t0, 1);
    chk("tmo_wb_only_next", n_wb - w0, 1);
    chk("tmo_next_issue", last_start - sa, 10);

    // Reset while waiting with two entries queued.
    dly = 99;
    offer(7, 1, 1, 1, 0);
    repeat (3) step();
    offer(8, 2, 2, 2, 0);
    offer(9, 3, 3, 3, 0);
    step();
    apply_reset();
    dly = 3;
    s0 = n_start; w0 = n_wb;
    repeat (20) step();
    chk("post_reset_starts", n_start - s0, 0);
    chk("post_reset_wb", n_wb - w0, 0);
    offer(12, 5, 6, 7, 0);
    repeat (10) step();
    chk("post_reset_issue", n_start - s0, 1);

    // Spurious ready in IDLE and START; ready with a push.
    w0 = n_wb;
    rdy_once = 1'b1;
    step();
    spur_start = 1'b1;
    offer(11, 6, 2, 4, 1);
    step();
    step();
    spur_start = 1'b0;
    step();
    step();
    offer(2, 3, 4, 5, 1);
    repeat (20) step();
    chk("spurious_wb", n_wb - w0, 2);

    // Random traffic against the model.
    dly = 0;
    spur_rand = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (!offer_v && $urandom_range(0, 9) < 4) begin
        o_op  = int'($urandom_range(0, 15));
        o_vd  = int'($urandom_range(0, 7));
        o_vs1 = int'($urandom_range(0, 7));
        o_vs2 = int'($urandom_range(0, 7));
        o_scl = ref_scalar(o_op);
        offer_v = 1'b1;
      end
      step();
    end
    spur_rand = 1'b0;
    dly = 3;
    repeat (80) step();
    chk("drain_queue", q.size(), 0);
    chk("drain_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
